// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the tap-sequencer block:
//   - default width constants for the coefficient address, the sample
//     ring-buffer address and the tap count
//   - the 2-bit FSM state encoding used by the sequencer
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_AW_DEF    = 10;
    localparam int TAPS_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ctrl_ramdrv_tapseq_if.sv
// ---------------------------------------------------------------------------
// ctrl_ramdrv_tapseq_if
// Bundles the request inputs and the RAM / MAC drive outputs of the
// tap sequencer.
//   master : requester side (drives start, coef_base, taps, data_head;
//            observes busy, done and all drive outputs)
//   slave  : sequencer side (the opposite directions)
// Clock and reset are not part of the bundle.
// ---------------------------------------------------------------------------
interface ctrl_ramdrv_tapseq_if
    import ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_AW    = DATA_AW_DEF,
    parameter int TAPS_WIDTH = TAPS_WIDTH_DEF
) ();

    logic                  start;
    logic [ADDR_WIDTH-1:0] coef_base;
    logic [TAPS_WIDTH-1:0] taps;
    logic [DATA_AW-1:0]    data_head;

    logic                  busy;
    logic                  done;
    logic                  coef_load;
    logic [ADDR_WIDTH-1:0] coef_ptr;
    logic                  coef_cnt;
    logic [DATA_AW-1:0]    data_addr;
    logic                  mac_clr;
    logic                  mac_en;
    logic                  mac_last;

    modport master (
        output start, coef_base, taps, data_head,
        input  busy, done, coef_load, coef_ptr, coef_cnt, data_addr,
               mac_clr, mac_en, mac_last
    );

    modport slave (
        input  start, coef_base, taps, data_head,
        output busy, done, coef_load, coef_ptr, coef_cnt, data_addr,
               mac_clr, mac_en, mac_last
    );

endinterface

// File: rtl/ctrl_ramdrv_datacnt.sv
// ---------------------------------------------------------------------------
// ctrl_ramdrv_datacnt
// Loadable down-counter producing the sample ring-buffer read address.
// Decrementing past 0 wraps to 2^WIDTH-1, which walks the ring buffer
// backwards from the newest sample.
//   clk, clr_n  : clock, asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (has priority over i_dec)
//   i_load_val  : value to load
//   i_dec       : decrement by one
//   o_cnt       : registered count
// ---------------------------------------------------------------------------
module ctrl_ramdrv_datacnt
    import ctrl_pkg::*;
#(
    parameter int WIDTH = DATA_AW_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ctrl_ramdrv_tapseq.sv
// ---------------------------------------------------------------------------
// ctrl_ramdrv_tapseq
// Sequencer for one polyphase FIR output: on start it latches the branch
// coefficient base, the tap count and the newest-sample address, spends
// one LOAD cycle presetting the coefficient counter and clearing the MAC,
// then runs `taps` MAC cycles walking the sample ring buffer backwards,
// and finishes with a one-cycle done pulse.
//   clk    : clock (posedge)
//   clr_n  : asynchronous active-low reset; all outputs forced to 0
//   bus    : slave side of ctrl_ramdrv_tapseq_if
//            in : start, coef_base, taps, data_head
//            out: busy, done, coef_load, coef_ptr, coef_cnt, data_addr,
//                 mac_clr, mac_en, mac_last
// All outputs are registered: the output flops are fed from the next state
// so each output lines up with the state it belongs to.
// ---------------------------------------------------------------------------
module ctrl_ramdrv_tapseq
    import ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_AW    = DATA_AW_DEF,
    parameter int TAPS_WIDTH = TAPS_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 clr_n,
    ctrl_ramdrv_tapseq_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_next;
    logic [TAPS_WIDTH-1:0] r_tap_cnt;
    logic [TAPS_WIDTH-1:0] w_tap_cnt_next;
    logic [ADDR_WIDTH-1:0] r_coef_ptr;
    logic                  w_accept;
    logic                  w_data_dec;
    logic [DATA_AW-1:0]    w_data_addr;

    logic r_busy, r_done, r_coef_load, r_coef_cnt, r_mac_clr, r_mac_en, r_mac_last;
    logic w_busy_next, w_done_next, w_coef_load_next, w_coef_cnt_next;
    logic w_mac_clr_next, w_mac_en_next, w_mac_last_next;

    // Requests are only honoured while idle.
    assign w_accept = (r_state == ST_IDLE) && bus.start;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // r_tap_cnt holds the number of RUN cycles still to go, including the
    // current one, so RUN ends when it reads 1. Counting down from the
    // latched value means taps = 2^TAPS_WIDTH-1 needs no extra bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = (r_tap_cnt == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (r_tap_cnt == TAPS_WIDTH'(1)) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tap_cnt_next = r_tap_cnt;
        if (w_accept) begin
            w_tap_cnt_next = bus.taps;
        end else if (r_state == ST_RUN) begin
            w_tap_cnt_next = r_tap_cnt - TAPS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tap_cnt  <= '0;
            r_coef_ptr <= '0;
        end else begin
            r_tap_cnt <= w_tap_cnt_next;
            if (w_accept) begin
                r_coef_ptr <= bus.coef_base;
            end
        end
    end

    // ---------------- output logic ----------------
    // Decoded from the next state and next tap count, then registered,
    // so e.g. mac_last is high exactly in the RUN cycle whose count is 1.
    always_comb begin
        w_busy_next      = (w_state_next != ST_IDLE);
        w_done_next      = (w_state_next == ST_DONE);
        w_coef_load_next = (w_state_next == ST_LOAD);
        w_mac_clr_next   = (w_state_next == ST_LOAD);
        w_coef_cnt_next  = (w_state_next == ST_RUN);
        w_mac_en_next    = (w_state_next == ST_RUN);
        w_mac_last_next  = (w_state_next == ST_RUN) && (w_tap_cnt_next == TAPS_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_coef_load <= 1'b0;
            r_coef_cnt  <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_last  <= 1'b0;
        end else begin
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_coef_load <= w_coef_load_next;
            r_coef_cnt  <= w_coef_cnt_next;
            r_mac_clr   <= w_mac_clr_next;
            r_mac_en    <= w_mac_en_next;
            r_mac_last  <= w_mac_last_next;
        end
    end

    // The sample address is loaded with the head on accept, so it shows
    // the head during LOAD and RUN cycle 0; each completed RUN cycle then
    // steps it back by one sample.
    assign w_data_dec = (r_state == ST_RUN);

    ctrl_ramdrv_datacnt #(
        .WIDTH (DATA_AW)
    ) u_datacnt (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_load     (w_accept),
        .i_load_val (bus.data_head),
        .i_dec      (w_data_dec),
        .o_cnt      (w_data_addr)
    );

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.coef_load = r_coef_load;
    assign bus.coef_ptr  = r_coef_ptr;
    assign bus.coef_cnt  = r_coef_cnt;
    assign bus.data_addr = w_data_addr;
    assign bus.mac_clr   = r_mac_clr;
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_last  = r_mac_last;

endmodule

// File: tb/tb_ctrl_ramdrv_tapseq.sv
// ---------------------------------------------------------------------------
// tb_ctrl_ramdrv_tapseq
// Directed bench for the tap sequencer. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point, so "cycle n"
// below means the cycle starting at the n-th edge after the start cycle.
// ---------------------------------------------------------------------------
module tb_ctrl_ramdrv_tapseq;

    localparam int AW = 12;
    localparam int DW = 10;
    localparam int TW = 8;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_ramdrv_tapseq_if #(.ADDR_WIDTH(AW), .DATA_AW(DW), .TAPS_WIDTH(TW)) bus ();

    ctrl_ramdrv_tapseq #(.ADDR_WIDTH(AW), .DATA_AW(DW), .TAPS_WIDTH(TW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    logic [AW+DW+6:0] outs;
    assign outs = {bus.busy, bus.done, bus.coef_load, bus.coef_cnt, bus.mac_clr,
                   bus.mac_en, bus.mac_last, bus.coef_ptr, bus.data_addr};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; returns in the LOAD cycle (cycle 1).
    task automatic do_start(input logic [AW-1:0] b, input logic [TW-1:0] t, input logic [DW-1:0] h);
        bus.coef_base = b;
        bus.taps      = t;
        bus.data_head = h;
        bus.start     = 1'b1;
        $display("[TB] txn start base=0x%03h taps=%0d head=0x%03h", b, t, h);
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        #1 clr_n = 1'b0;
        #1;
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_async_outs got=%h exp=0", outs); end
        step(); step();
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_held_outs got=%h exp=0", outs); end
        clr_n = 1'b1;
        step();
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL reset_idle_outs got=%h exp=0", outs); end
    endtask

    task automatic test_basic;
        logic [DW-1:0] exp_addr;
        do_start(12'h100, 8'd4, 10'h005);
        n_tests++; if (bus.coef_load !== 1'b1) begin n_fail++; $display("FAIL basic_coef_load got=%b exp=1", bus.coef_load); end
        n_tests++; if (bus.mac_clr !== 1'b1) begin n_fail++; $display("FAIL basic_mac_clr got=%b exp=1", bus.mac_clr); end
        n_tests++; if (bus.coef_ptr !== 12'h100) begin n_fail++; $display("FAIL basic_coef_ptr got=%h exp=100", bus.coef_ptr); end
        n_tests++; if (bus.data_addr !== 10'h005) begin n_fail++; $display("FAIL basic_load_addr got=%h exp=005", bus.data_addr); end
        n_tests++; if ({bus.busy, bus.coef_cnt, bus.mac_en} !== 3'b100) begin n_fail++; $display("FAIL basic_load_flags got=%b exp=100", {bus.busy, bus.coef_cnt, bus.mac_en}); end
        for (int k = 0; k < 4; k++) begin
            step();
            exp_addr = 10'(5 - k);
            n_tests++; if (bus.data_addr !== exp_addr) begin n_fail++; $display("FAIL basic_run_addr k=%0d got=%h exp=%h", k, bus.data_addr, exp_addr); end
            n_tests++; if ({bus.coef_cnt, bus.mac_en, bus.coef_load, bus.mac_clr, bus.busy} !== 5'b11001) begin n_fail++; $display("FAIL basic_run_flags k=%0d got=%b exp=11001", k, {bus.coef_cnt, bus.mac_en, bus.coef_load, bus.mac_clr, bus.busy}); end
            n_tests++; if (bus.mac_last !== (k == 3)) begin n_fail++; $display("FAIL basic_mac_last k=%0d got=%b exp=%b", k, bus.mac_last, (k == 3)); end
        end
        step();
        n_tests++; if ({bus.done, bus.busy, bus.mac_en} !== 3'b110) begin n_fail++; $display("FAIL basic_done got=%b exp=110", {bus.done, bus.busy, bus.mac_en}); end
        step();
        n_tests++; if ({bus.done, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle got=%b exp=00", {bus.done, bus.busy}); end
        n_tests++; if (bus.coef_ptr !== 12'h100) begin n_fail++; $display("FAIL basic_ptr_hold got=%h exp=100", bus.coef_ptr); end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] exp_tab [3];
        exp_tab = '{10'h001, 10'h000, 10'h3FF};
        do_start(12'h010, 8'd3, 10'h001);
        n_tests++; if (bus.data_addr !== 10'h001) begin n_fail++; $display("FAIL wrap_load_addr got=%h exp=001", bus.data_addr); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++; if (bus.data_addr !== exp_tab[k]) begin n_fail++; $display("FAIL wrap_addr k=%0d got=%h exp=%h", k, bus.data_addr, exp_tab[k]); end
        end
        step();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got=%b exp=1", bus.done); end
        step();
    endtask

    task automatic test_taps_zero;
        int busy_cyc = 0;
        int en_cyc   = 0;
        int done_at  = -1;
        do_start(12'h020, 8'd0, 10'h100);
        n_tests++; if ({bus.coef_load, bus.mac_clr} !== 2'b11) begin n_fail++; $display("FAIL zero_load got=%b exp=11", {bus.coef_load, bus.mac_clr}); end
        for (int c = 1; c <= 5; c++) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.mac_en !== 1'b0) en_cyc++;
            if (bus.done === 1'b1 && done_at < 0) done_at = c;
            step();
        end
        n_tests++; if (done_at !== 2) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=2", done_at); end
        n_tests++; if (busy_cyc !== 2) begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=2", busy_cyc); end
        n_tests++; if (en_cyc !== 0) begin n_fail++; $display("FAIL zero_mac_en got=%0d exp=0", en_cyc); end
    endtask

    task automatic test_start_ignored;
        int n_done = 0;
        do_start(12'h100, 8'd4, 10'h005);
        for (int c = 1; c <= 10; c++) begin
            if (bus.done === 1'b1) n_done++;
            if (c == 4) begin
                n_tests++; if (bus.data_addr !== 10'h003) begin n_fail++; $display("FAIL ign_run_addr got=%h exp=003", bus.data_addr); end
            end
            if (c == 6) begin
                n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_done_cycle got=%b exp=1", bus.done); end
            end
            if (c == 7) begin
                n_tests++; if ({bus.busy, bus.coef_load} !== 2'b00) begin n_fail++; $display("FAIL ign_no_restart got=%b exp=00", {bus.busy, bus.coef_load}); end
            end
            if (c == 3 || c == 6) begin
                bus.coef_base = 12'h2AA; bus.taps = 8'd9; bus.data_head = 10'h077; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.start = 1'b0;
        n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL ign_done_count got=%0d exp=1", n_done); end
        n_tests++; if (bus.coef_ptr !== 12'h100) begin n_fail++; $display("FAIL ign_coef_ptr got=%h exp=100", bus.coef_ptr); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_final_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_run;
        int n_done = 0;
        do_start(12'h300, 8'd8, 10'h020);
        step(); step(); step();
        n_tests++; if ({bus.mac_en, bus.data_addr} !== {1'b1, 10'h01E}) begin n_fail++; $display("FAIL rst_pre_run got=%h exp=%h", {bus.mac_en, bus.data_addr}, {1'b1, 10'h01E}); end
        #2 clr_n = 1'b0;
        #1;
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_async got=%h exp=0", outs); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.done !== 1'b0) n_done++;
        end
        clr_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.done !== 1'b0) n_done++;
        end
        n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL rst_no_done got=%0d exp=0", n_done); end
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL rst_not_resumed got=%h exp=0", outs); end
        do_start(12'h040, 8'd2, 10'h010);
        n_tests++; if ({bus.coef_load, bus.coef_ptr, bus.data_addr} !== {1'b1, 12'h040, 10'h010}) begin n_fail++; $display("FAIL rst_new_load got=%h exp=%h", {bus.coef_load, bus.coef_ptr, bus.data_addr}, {1'b1, 12'h040, 10'h010}); end
        step();
        n_tests++; if ({bus.mac_en, bus.mac_last, bus.data_addr} !== {2'b10, 10'h010}) begin n_fail++; $display("FAIL rst_new_run0 got=%h exp=%h", {bus.mac_en, bus.mac_last, bus.data_addr}, {2'b10, 10'h010}); end
        step();
        n_tests++; if ({bus.mac_en, bus.mac_last, bus.data_addr} !== {2'b11, 10'h00F}) begin n_fail++; $display("FAIL rst_new_run1 got=%h exp=%h", {bus.mac_en, bus.mac_last, bus.data_addr}, {2'b11, 10'h00F}); end
        step();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rst_new_done got=%b exp=1", bus.done); end
        step();
    endtask

    task automatic test_back_to_back;
        do_start(12'h0A0, 8'd2, 10'h200);
        step(); step(); step();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done got=%b exp=1", bus.done); end
        step();
        do_start(12'h0B0, 8'd1, 10'h201);
        n_tests++; if ({bus.coef_load, bus.coef_ptr} !== {1'b1, 12'h0B0}) begin n_fail++; $display("FAIL b2b_second_load got=%h exp=%h", {bus.coef_load, bus.coef_ptr}, {1'b1, 12'h0B0}); end
        step();
        n_tests++; if ({bus.mac_last, bus.data_addr} !== {1'b1, 10'h201}) begin n_fail++; $display("FAIL b2b_second_run got=%h exp=%h", {bus.mac_last, bus.data_addr}, {1'b1, 10'h201}); end
        step();
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b exp=1", bus.done); end
        step();
    endtask

    task automatic test_long;
        int n_cnt = 0;
        int n_last = 0;
        int last_pos_bad = 0;
        int overlap = 0;
        int done_at = -1;
        logic [DW-1:0] last_addr = '0;
        do_start(12'hF00, 8'd255, 10'h005);
        for (int c = 1; c <= 300 && done_at < 0; c++) begin
            if (bus.coef_cnt === 1'b1) begin
                n_cnt++;
                last_addr = bus.data_addr;
            end
            if (bus.mac_last === 1'b1) begin
                n_last++;
                if (n_cnt != 255 || bus.coef_cnt !== 1'b1) last_pos_bad++;
            end
            if (bus.coef_load === 1'b1 && bus.coef_cnt === 1'b1) overlap++;
            if (bus.done === 1'b1) done_at = c;
            else step();
        end
        n_tests++; if (n_cnt !== 255) begin n_fail++; $display("FAIL long_coef_cnt got=%0d exp=255", n_cnt); end
        n_tests++; if (n_last !== 1 || last_pos_bad !== 0) begin n_fail++; $display("FAIL long_mac_last got=%0d/%0d exp=1/0", n_last, last_pos_bad); end
        n_tests++; if (overlap !== 0) begin n_fail++; $display("FAIL long_load_cnt_overlap got=%0d exp=0", overlap); end
        n_tests++; if (done_at !== 257) begin n_fail++; $display("FAIL long_done_cycle got=%0d exp=257", done_at); end
        n_tests++; if (last_addr !== 10'h307) begin n_fail++; $display("FAIL long_last_addr got=%h exp=307", last_addr); end
        n_tests++; if (bus.coef_ptr !== 12'hF00) begin n_fail++; $display("FAIL long_coef_ptr got=%h exp=F00", bus.coef_ptr); end
        step();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.coef_base = '0;
        bus.taps      = '0;
        bus.data_head = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_taps_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_long();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
